// File: rtl/macro_timer_decr_pkg.sv
// Shared definitions for the loadable countdown timer.
//   timer_state_e : IDLE/RUN/DONE FSM encoding
//   SliceW        : bit width of one decrement ROM slice
package macro_timer_decr_pkg;

  localparam int unsigned SliceW = 2;

  typedef enum logic [1:0] {
    TIMER_IDLE = 2'd0,
    TIMER_RUN  = 2'd1,
    TIMER_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/macro_rom_decr2.sv
// Combinational 2-bit decrement ROM slice.
//   d  : slice value in
//   bi : borrow in; when low the slice passes d through unchanged
//   q  : d-1 mod 4 when bi is high, else d
//   bo : borrow out, high only when bi is high and d is zero
module macro_rom_decr2 (
  input  logic [1:0] d,
  input  logic       bi,
  output logic [1:0] q,
  output logic       bo
);

  always_comb begin
    q  = d;
    bo = 1'b0;
    if (bi) begin
      case (d)
        2'd0: begin
          q  = 2'd3;
          bo = 1'b1;
        end
        2'd1:    q = 2'd0;
        2'd2:    q = 2'd1;
        2'd3:    q = 2'd2;
        default: q = d;
      endcase
    end
  end

endmodule

// File: rtl/macro_timer_decr.sv
// Loadable countdown timer with a valid/ready load port and a one-cycle done pulse.
//   clk, resetn    : clock (rising edge) and asynchronous active-low reset
//   i_load_valid   : load request; accepted when o_load_ready is high
//   i_load_value   : initial count
//   o_load_ready   : high in IDLE
//   i_en           : tick enable, one decrement per enabled RUN cycle
//   i_abort        : cancel a running count (no done pulse)
//   o_busy         : high in RUN
//   o_cnt          : current count register
//   o_done         : one-cycle terminal-count pulse
//   o_borrow       : borrow out of the top slice for o_cnt (high iff o_cnt == 0)
// WIDTH must be even and at least 2.
module macro_timer_decr
  import macro_timer_decr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_load_ready,
  input  logic             i_en,
  input  logic             i_abort,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_done,
  output logic             o_borrow
);

  localparam int unsigned NSlices = WIDTH / SliceW;

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cnt_dec;
  logic [NSlices:0] borrow;

  // Ripple borrow chain: the bottom slice always decrements.
  assign borrow[0] = 1'b1;

  for (genvar k = 0; k < NSlices; k++) begin : g_slice
    macro_rom_decr2 u_rom (
      .d  (cnt_q[SliceW*k +: SliceW]),
      .bi (borrow[k]),
      .q  (cnt_dec[SliceW*k +: SliceW]),
      .bo (borrow[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      TIMER_IDLE: begin
        if (i_load_valid) begin
          if (i_load_value != '0) begin
            cnt_d   = i_load_value;
            state_d = TIMER_RUN;
          end else begin
            cnt_d   = '0;
            state_d = TIMER_DONE;
          end
        end
      end
      TIMER_RUN: begin
        // Abort outranks a tick in the same cycle.
        if (i_abort) begin
          cnt_d   = '0;
          state_d = TIMER_IDLE;
        end else if (i_en) begin
          if (cnt_q == WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = TIMER_DONE;
          end else begin
            cnt_d = cnt_dec;
          end
        end
      end
      TIMER_DONE: begin
        state_d = TIMER_IDLE;
      end
      default: begin
        state_d = TIMER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= TIMER_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_load_ready = (state_q == TIMER_IDLE);
  assign o_busy       = (state_q == TIMER_RUN);
  assign o_done       = (state_q == TIMER_DONE);
  assign o_cnt        = cnt_q;
  assign o_borrow     = borrow[NSlices];

endmodule

// File: tb/tb_macro_timer_decr.sv
// Scoreboard bench for macro_timer_decr at WIDTH = 2, 8 and 16, run side by side.
module tb_macro_timer_decr;

  typedef struct {
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        ready;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  function automatic void chk(input string tag, input int w, input logic [15:0] act,
                              input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s (W=%0d): got 0x%0h, required 0x%0h", tag, w, act, req);
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int unsigned W       = (gi == 0) ? 2 : ((gi == 1) ? 8 : 16);
    localparam int          AllOnes = (1 << W) - 1;
    localparam int          Half    = 1 << (W - 1);
    localparam int          NA      = (W == 2) ? 3 : 5;
    localparam int          N3      = (W == 2) ? 3 : 4;
    localparam int          RipLo   = (W == 2) ? 3 : 'h11;
    localparam logic [5:0]  EnPat   = 6'b111001;  // applied LSB first: 1,0,0,1,1,1

    logic         resetn;
    logic         load_valid;
    logic [W-1:0] load_value;
    logic         load_ready;
    logic         en;
    logic         abort;
    logic         busy;
    logic [W-1:0] cnt;
    logic         done;
    logic         borrow;
    bit           fin = 1'b0;
    event         sample_ev;
    exp_t         q[$];

    macro_timer_decr #(.WIDTH(W)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .i_load_valid (load_valid),
      .i_load_value (load_value),
      .o_load_ready (load_ready),
      .i_en         (en),
      .i_abort      (abort),
      .o_busy       (busy),
      .o_cnt        (cnt),
      .o_done       (done),
      .o_borrow     (borrow)
    );

    task automatic push_exp(input logic [W-1:0] ecnt, input logic ebusy, input logic edone,
                            input logic eready, input string tag);
      exp_t e;
      e.cnt   = 16'(ecnt);
      e.busy  = ebusy;
      e.done  = edone;
      e.ready = eready;
      e.tag   = tag;
      q.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the state expected after the next rising edge.
    task automatic cyc(input logic lv, input logic [W-1:0] val, input logic e_n, input logic ab,
                       input logic [W-1:0] ecnt, input logic ebusy, input logic edone,
                       input logic eready, input string tag);
      @(negedge clk);
      load_valid = lv;
      load_value = val;
      en         = e_n;
      abort      = ab;
      push_exp(ecnt, ebusy, edone, eready, tag);
    endtask

    // Monitor: compare after each rising edge, or on demand for asynchronous events.
    initial begin
      exp_t e;
      forever begin
        @(posedge clk or sample_ev);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk({e.tag, " cnt"}, W, 16'(cnt), e.cnt);
          chk({e.tag, " busy"}, W, 16'(busy), 16'(e.busy));
          chk({e.tag, " done"}, W, 16'(done), 16'(e.done));
          chk({e.tag, " ready"}, W, 16'(load_ready), 16'(e.ready));
          chk({e.tag, " borrow"}, W, 16'(borrow), 16'(e.cnt == 16'd0));
        end
      end
    end

    initial begin
      int   c;
      bit   running;
      logic e_i;
      resetn     = 1'b0;
      load_valid = 1'b0;
      load_value = '0;
      en         = 1'b0;
      abort      = 1'b0;
      #2;
      push_exp('0, 1'b0, 1'b0, 1'b1, "reset");
      -> sample_ev;
      @(negedge clk);
      resetn = 1'b1;

      // Plain countdown with enable held high.
      cyc(1, W'(NA), 1, 0, W'(NA), 1, 0, 0, "t1 load");
      for (int k = NA - 1; k >= 1; k--) cyc(0, '0, 1, 0, W'(k), 1, 0, 0, "t1 count");
      cyc(0, '0, 1, 0, '0, 0, 1, 0, "t1 done");
      cyc(0, '0, 1, 0, '0, 0, 0, 1, "t1 ready");

      // Zero load goes straight to DONE.
      cyc(1, '0, 1, 0, '0, 0, 1, 0, "t2 zero done");
      cyc(0, '0, 1, 0, '0, 0, 0, 1, "t2 idle");

      // Gated enable.
      cyc(1, W'(N3), 0, 0, W'(N3), 1, 0, 0, "t3 load");
      c       = N3;
      running = 1'b1;
      for (int i = 0; i < 6; i++) begin
        e_i = EnPat[i];
        if (running) begin
          if (e_i) c--;
          if (c == 0) begin
            cyc(0, '0, e_i, 0, '0, 0, 1, 0, "t3 done");
            running = 1'b0;
          end else begin
            cyc(0, '0, e_i, 0, W'(c), 1, 0, 0, "t3 gated");
          end
        end else begin
          cyc(0, '0, e_i, 0, '0, 0, 0, 1, "t3 idle");
        end
      end
      cyc(0, '0, 0, 0, '0, 0, 0, 1, "t3 after");

      // Long count from all ones, aborted at the top-bit boundary.
      cyc(1, W'(AllOnes), 1, 0, W'(AllOnes), 1, 0, 0, "t4 load");
      for (int k = AllOnes - 1; k >= Half; k--) cyc(0, '0, 1, 0, W'(k), 1, 0, 0, "t4 count");
      cyc(0, '0, 1, 1, '0, 0, 0, 1, "t4 abort");
      cyc(0, '0, 1, 0, '0, 0, 0, 1, "t4 no done");

      // Borrow ripple across the top slice boundary and a mid boundary.
      cyc(1, W'(Half + 1), 1, 0, W'(Half + 1), 1, 0, 0, "rip hi load");
      cyc(0, '0, 1, 0, W'(Half), 1, 0, 0, "rip hi step");
      cyc(0, '0, 1, 0, W'(Half - 1), 1, 0, 0, "rip hi borrow");
      cyc(0, '0, 0, 1, '0, 0, 0, 1, "rip hi abort");
      cyc(1, W'(RipLo), 1, 0, W'(RipLo), 1, 0, 0, "rip lo load");
      cyc(0, '0, 1, 0, W'(RipLo - 1), 1, 0, 0, "rip lo step");
      cyc(0, '0, 1, 0, W'(RipLo - 2), 1, 0, 0, "rip lo borrow");
      cyc(0, '0, 0, 1, '0, 0, 0, 1, "rip lo abort");

      // Load ignored in RUN, abort beats terminal tick, abort/load ignored in IDLE/DONE.
      cyc(1, W'(2), 1, 0, W'(2), 1, 0, 0, "t5 load");
      cyc(1, W'(3), 0, 0, W'(2), 1, 0, 0, "t5 load in run");
      cyc(0, '0, 1, 0, W'(1), 1, 0, 0, "t5 at one");
      cyc(0, '0, 1, 1, '0, 0, 0, 1, "t5 abort wins");
      cyc(0, '0, 0, 1, '0, 0, 0, 1, "t5 abort idle");
      cyc(1, '0, 0, 0, '0, 0, 1, 0, "t5 zero done");
      cyc(1, W'(3), 0, 1, '0, 0, 0, 1, "t5 load in done");
      cyc(0, '0, 0, 0, '0, 0, 0, 1, "t5 idle");

      // Asynchronous reset mid-count, then a fresh load.
      cyc(1, W'(NA), 1, 0, W'(NA), 1, 0, 0, "t6 load");
      for (int k = NA - 1; k >= 3; k--) cyc(0, '0, 1, 0, W'(k), 1, 0, 0, "t6 count");
      @(negedge clk);
      #2;
      resetn = 1'b0;
      push_exp('0, 0, 0, 1, "t6 async reset");
      -> sample_ev;
      cyc(0, '0, 1, 0, '0, 0, 0, 1, "t6 held reset");
      @(negedge clk);
      resetn = 1'b1;
      cyc(1, W'(2), 1, 0, W'(2), 1, 0, 0, "t6 reload");
      cyc(0, '0, 1, 0, W'(1), 1, 0, 0, "t6 count");
      cyc(0, '0, 1, 0, '0, 0, 1, 0, "t6 done");
      cyc(0, '0, 1, 0, '0, 0, 0, 1, "t6 ready");

      repeat (3) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int waited = 0;
    while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && waited < 150000) begin
      @(posedge clk);
      waited++;
    end
    if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
      n_checks++;
      n_fails++;
      $display("FAIL timeout: stimulus finished=0, required 1 within %0d cycles", waited);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
